// File: rtl/rf_wr_arb.sv
// Register-file write-port arbiter: the pipeline writeback has priority, and long-latency
// results are buffered in a small FIFO whose head is force-granted after STARVE_MAX denials.
module rf_wr_arb #(
  parameter int WORD_W     = 32,
  parameter int REG_IDX_W  = 5,
  parameter int QDEPTH     = 2,
  parameter int STARVE_MAX = 4
) (
  input  logic                 clk,
  input  logic                 clr,
  input  logic                 i_pipe_en,
  input  logic [REG_IDX_W-1:0] i_pipe_reg,
  input  logic [WORD_W-1:0]    i_pipe_data,
  input  logic                 i_ll_valid,
  output logic                 o_ll_ready,
  input  logic [REG_IDX_W-1:0] i_ll_reg,
  input  logic [WORD_W-1:0]    i_ll_data,
  output logic                 o_stall,
  output logic                 o_busy,
  output logic                 o_rf_we,
  output logic [REG_IDX_W-1:0] o_rf_waddr,
  output logic [WORD_W-1:0]    o_rf_wdata
);

  localparam int PTR_W = (QDEPTH > 1) ? $clog2(QDEPTH) : 1;
  localparam int CNT_W = $clog2(QDEPTH + 1);
  localparam int ST_W  = $clog2(STARVE_MAX + 1);
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(QDEPTH);
  localparam logic [ST_W-1:0]  ST_LIMIT = ST_W'(STARVE_MAX);

  typedef enum logic [2:0] {
    GNT_NONE, GNT_FORCED, GNT_PIPE, GNT_FIFO, GNT_BYPASS
  } gnt_e;

  logic [REG_IDX_W-1:0] reg_mem  [QDEPTH];
  logic [WORD_W-1:0]    data_mem [QDEPTH];
  logic [PTR_W-1:0]     rd_ptr, wr_ptr;
  logic [CNT_W-1:0]     count;
  logic [ST_W-1:0]      starve_cnt, starve_nxt;

  logic                 fifo_empty, fifo_full;
  logic                 ll_xfer, ll_live, pipe_live;
  logic                 push, pop;
  gnt_e                 gnt;
  logic                 we_d;
  logic [REG_IDX_W-1:0] waddr_d;
  logic [WORD_W-1:0]    wdata_d;

  // Long-latency handshake: a transfer happens on a rising edge where i_ll_valid && o_ll_ready;
  // o_ll_ready depends only on occupancy, so a full FIFO never takes a same-cycle pass-through.
  always_comb begin
    fifo_empty = (count == '0);
    fifo_full  = (count == FULL_CNT);
    o_ll_ready = !fifo_full;
    o_busy     = !fifo_empty;
    o_stall    = !fifo_empty && (starve_cnt == ST_LIMIT);
    ll_xfer    = i_ll_valid && !fifo_full;
    ll_live    = ll_xfer && (i_ll_reg != '0);
    pipe_live  = i_pipe_en && (i_pipe_reg != '0);
  end

  always_comb begin
    gnt     = GNT_NONE;
    pop     = 1'b0;
    we_d    = 1'b0;
    waddr_d = o_rf_waddr;
    wdata_d = o_rf_wdata;
    if (o_stall) begin
      gnt = GNT_FORCED;
    end else if (pipe_live) begin
      gnt = GNT_PIPE;
    end else if (!fifo_empty) begin
      gnt = GNT_FIFO;
    end else if (ll_live) begin
      gnt = GNT_BYPASS;
    end
    case (gnt)
      GNT_FORCED, GNT_FIFO: begin
        pop     = 1'b1;
        we_d    = 1'b1;
        waddr_d = reg_mem[rd_ptr];
        wdata_d = data_mem[rd_ptr];
      end
      GNT_PIPE: begin
        we_d    = 1'b1;
        waddr_d = i_pipe_reg;
        wdata_d = i_pipe_data;
      end
      GNT_BYPASS: begin
        we_d    = 1'b1;
        waddr_d = i_ll_reg;
        wdata_d = i_ll_data;
      end
      default: ;
    endcase
    // Reg-0 results were already dropped by ll_live, so they never take a slot.
    push = ll_live && (gnt != GNT_BYPASS);
  end

  always_comb begin
    starve_nxt = starve_cnt;
    if (fifo_empty || pop) begin
      starve_nxt = '0;
    end else if (starve_cnt != ST_LIMIT) begin
      starve_nxt = starve_cnt + ST_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (clr) begin
      rd_ptr     <= '0;
      wr_ptr     <= '0;
      count      <= '0;
      starve_cnt <= '0;
      o_rf_we    <= 1'b0;
      o_rf_waddr <= '0;
      o_rf_wdata <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
      starve_cnt <= starve_nxt;
      o_rf_we    <= we_d;
      o_rf_waddr <= waddr_d;
      o_rf_wdata <= wdata_d;
    end
  end

  // Storage is not reset; occupancy and pointers alone decide what is valid.
  always_ff @(posedge clk) begin
    if (push && !clr) begin
      reg_mem[wr_ptr]  <= i_ll_reg;
      data_mem[wr_ptr] <= i_ll_data;
    end
  end

endmodule

// File: tb/tb_rf_wr_arb.sv
// Bench for rf_wr_arb: a queue-based reference model checked every cycle, plus directed
// scenarios with hand-computed literal expectations.
module tb_rf_wr_arb;
  localparam int WORD_W     = 32;
  localparam int REG_IDX_W  = 5;
  localparam int QDEPTH     = 2;
  localparam int STARVE_MAX = 4;

  logic                 clk;
  logic                 clr;
  logic                 i_pipe_en;
  logic [REG_IDX_W-1:0] i_pipe_reg;
  logic [WORD_W-1:0]    i_pipe_data;
  logic                 i_ll_valid;
  logic                 o_ll_ready;
  logic [REG_IDX_W-1:0] i_ll_reg;
  logic [WORD_W-1:0]    i_ll_data;
  logic                 o_stall;
  logic                 o_busy;
  logic                 o_rf_we;
  logic [REG_IDX_W-1:0] o_rf_waddr;
  logic [WORD_W-1:0]    o_rf_wdata;

  rf_wr_arb #(
    .WORD_W(WORD_W), .REG_IDX_W(REG_IDX_W), .QDEPTH(QDEPTH), .STARVE_MAX(STARVE_MAX)
  ) dut (
    .clk(clk), .clr(clr),
    .i_pipe_en(i_pipe_en), .i_pipe_reg(i_pipe_reg), .i_pipe_data(i_pipe_data),
    .i_ll_valid(i_ll_valid), .o_ll_ready(o_ll_ready),
    .i_ll_reg(i_ll_reg), .i_ll_data(i_ll_data),
    .o_stall(o_stall), .o_busy(o_busy),
    .o_rf_we(o_rf_we), .o_rf_waddr(o_rf_waddr), .o_rf_wdata(o_rf_wdata)
  );

  // ---------------- clock / watchdog ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, want finish");
    $fatal(1, "watchdog");
  end

  // ---------------- scoreboard ----------------
  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, want 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  typedef struct packed {
    logic [REG_IDX_W-1:0] r;
    logic [WORD_W-1:0]    d;
  } ent_t;

  ent_t                 mq[$];
  int                   m_starve = 0;
  logic                 m_we = 1'b0;
  logic [REG_IDX_W-1:0] m_addr = '0;
  logic [WORD_W-1:0]    m_data = '0;
  bit                   m_valid = 1'b0;

  always @(posedge clk) begin : model
    bit   was_empty;
    bit   ll_ok;
    bit   head_gnt;
    ent_t e;
    if (clr) begin
      mq.delete();
      m_starve = 0;
      m_we     = 1'b0;
      m_addr   = '0;
      m_data   = '0;
      m_valid  = 1'b1;
    end else begin
      was_empty = (mq.size() == 0);
      ll_ok     = i_ll_valid && (mq.size() < QDEPTH) && (i_ll_reg != 0);
      head_gnt  = 1'b0;
      m_we      = 1'b1;
      if (!was_empty && m_starve == STARVE_MAX) head_gnt = 1'b1;
      else if (i_pipe_en && i_pipe_reg != 0) begin
        m_addr = i_pipe_reg;
        m_data = i_pipe_data;
      end else if (!was_empty) head_gnt = 1'b1;
      else if (ll_ok) begin
        m_addr = i_ll_reg;
        m_data = i_ll_data;
        ll_ok  = 1'b0;
      end else m_we = 1'b0;
      if (head_gnt) begin
        e = mq.pop_front();
        m_addr = e.r;
        m_data = e.d;
      end
      if (ll_ok) begin
        e.r = i_ll_reg;
        e.d = i_ll_data;
        mq.push_back(e);
      end
      if (was_empty || head_gnt) m_starve = 0;
      else if (m_starve < STARVE_MAX) m_starve = m_starve + 1;
    end
  end

  always @(negedge clk) begin
    if (m_valid) begin
      chk("rf_we", o_rf_we, m_we);
      if (m_we) begin
        chk("rf_waddr", o_rf_waddr, m_addr);
        chk("rf_wdata", o_rf_wdata, m_data);
      end
      chk("busy", o_busy, mq.size() != 0);
      chk("ll_ready", o_ll_ready, mq.size() < QDEPTH);
      chk("stall", o_stall, (mq.size() != 0) && (m_starve == STARVE_MAX));
    end
  end

  // ---------------- write monitors ----------------
  bit                   rec_ll = 1'b0;
  bit                   rec_stale = 1'b0;
  logic [REG_IDX_W-1:0] obs_q[$];
  int                   stale_cnt = 0;

  always @(negedge clk) begin
    if (rec_ll && o_rf_we && o_rf_waddr >= 10 && o_rf_waddr <= 12) obs_q.push_back(o_rf_waddr);
    if (rec_stale && o_rf_we) stale_cnt++;
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic ll_push(input logic [REG_IDX_W-1:0] r, input logic [WORD_W-1:0] d,
                         output int waited);
    i_ll_valid = 1'b1;
    i_ll_reg   = r;
    i_ll_data  = d;
    waited     = 0;
    while (!o_ll_ready && waited < 20) begin
      tick();
      waited++;
    end
    tick();
    i_ll_valid = 1'b0;
  endtask

  task automatic idle_inputs();
    i_pipe_en   = 1'b0;
    i_pipe_reg  = '0;
    i_pipe_data = '0;
    i_ll_valid  = 1'b0;
    i_ll_reg    = '0;
    i_ll_data   = '0;
  endtask

  // ---------------- directed stimulus ----------------
  initial begin
    int w;
    clr = 1'b1;
    idle_inputs();
    tick();
    tick();
    chk("rst_we", o_rf_we, 0);
    chk("rst_waddr", o_rf_waddr, 0);
    chk("rst_wdata", o_rf_wdata, 0);
    chk("rst_ready", o_ll_ready, 1);
    chk("rst_stall", o_stall, 0);
    chk("rst_busy", o_busy, 0);
    clr = 1'b0;
    tick();

    // Bypass: empty FIFO, single long-latency result written next cycle.
    i_ll_valid = 1'b1; i_ll_reg = 5'd3; i_ll_data = 32'hDEADBEEF;
    chk("byp_busy_pre", o_busy, 0);
    tick();
    i_ll_valid = 1'b0;
    chk("byp_we", o_rf_we, 1);
    chk("byp_waddr", o_rf_waddr, 3);
    chk("byp_wdata", o_rf_wdata, 32'hDEADBEEF);
    chk("byp_busy", o_busy, 0);
    tick();
    chk("byp_we_after", o_rf_we, 0);

    // Priority: pipe wins, long-latency result follows from the FIFO.
    i_pipe_en = 1'b1; i_pipe_reg = 5'd5; i_pipe_data = 32'h11;
    i_ll_valid = 1'b1; i_ll_reg = 5'd6; i_ll_data = 32'h22;
    tick();
    idle_inputs();
    chk("pri_waddr1", o_rf_waddr, 5);
    chk("pri_wdata1", o_rf_wdata, 32'h11);
    chk("pri_busy1", o_busy, 1);
    tick();
    chk("pri_waddr2", o_rf_waddr, 6);
    chk("pri_wdata2", o_rf_wdata, 32'h22);
    chk("pri_busy2", o_busy, 0);
    tick();
    chk("pri_we3", o_rf_we, 0);

    // Starvation: 4 stall-free pipe cycles, 1 stall, queued entry, then held pipe write.
    i_pipe_en = 1'b1; i_pipe_reg = 5'd7; i_pipe_data = 32'h70;
    i_ll_valid = 1'b1; i_ll_reg = 5'd9; i_ll_data = 32'h99;
    tick();
    i_ll_valid = 1'b0;
    chk("stv_waddr0", o_rf_waddr, 7);
    chk("stv_stall0", o_stall, 0);
    for (int k = 1; k < 4; k++) begin
      tick();
      chk("stv_stall_k", o_stall, 0);
      chk("stv_waddr_k", o_rf_waddr, 7);
    end
    tick();
    chk("stv_stall", o_stall, 1);
    tick();
    chk("stv_ll_waddr", o_rf_waddr, 9);
    chk("stv_ll_wdata", o_rf_wdata, 32'h99);
    chk("stv_stall_end", o_stall, 0);
    tick();
    chk("stv_held_waddr", o_rf_waddr, 7);
    chk("stv_held_wdata", o_rf_wdata, 32'h70);
    idle_inputs();
    tick();

    // Full/backpressure: third entry waits until the forced pop frees a slot.
    rec_ll = 1'b1;
    i_pipe_en = 1'b1; i_pipe_reg = 5'd8; i_pipe_data = 32'h80;
    ll_push(5'd10, 32'hA0, w);
    chk("full_wait_a", w, 0);
    ll_push(5'd11, 32'hB0, w);
    chk("full_wait_b", w, 0);
    chk("full_ready_lo", o_ll_ready, 0);
    ll_push(5'd12, 32'hC0, w);
    chk("full_wait_c", w, 4);
    repeat (20) tick();
    idle_inputs();
    tick();
    rec_ll = 1'b0;
    chk("full_nwrites", obs_q.size(), 3);
    if (obs_q.size() == 3) begin
      chk("full_order0", obs_q[0], 10);
      chk("full_order1", obs_q[1], 11);
      chk("full_order2", obs_q[2], 12);
    end

    // Reg-0 filter on both sources.
    i_pipe_en = 1'b1; i_pipe_reg = 5'd0; i_pipe_data = 32'h55;
    i_ll_valid = 1'b1; i_ll_reg = 5'd0; i_ll_data = 32'h66;
    tick();
    idle_inputs();
    chk("r0_we", o_rf_we, 0);
    chk("r0_busy", o_busy, 0);
    tick();
    chk("r0_we2", o_rf_we, 0);
    chk("r0_busy2", o_busy, 0);

    // Mixed directed pattern, checked by the model every cycle.
    for (int i = 0; i < 24; i++) begin
      i_pipe_en   = (i % 3) != 0;
      i_pipe_reg  = REG_IDX_W'(i % 8);
      i_pipe_data = 32'(i * 32'h101);
      i_ll_valid  = (i % 2) == 0;
      i_ll_reg    = REG_IDX_W'((i + 1) % 6);
      i_ll_data   = 32'(32'hC000 + i);
      tick();
    end
    idle_inputs();
    repeat (15) tick();
    chk("mix_drained", o_busy, 0);

    // Reset mid-operation with two queued entries.
    i_pipe_en = 1'b1; i_pipe_reg = 5'd8; i_pipe_data = 32'h88;
    ll_push(5'd13, 32'hD0, w);
    chk("rst_wait_a", w, 0);
    ll_push(5'd14, 32'hE0, w);
    chk("rst_wait_b", w, 0);
    chk("rst_busy_pre", o_busy, 1);
    clr = 1'b1;
    i_ll_valid = 1'b1; i_ll_reg = 5'd15; i_ll_data = 32'hF0;
    tick();
    clr = 1'b0;
    idle_inputs();
    chk("mrst_we", o_rf_we, 0);
    chk("mrst_busy", o_busy, 0);
    chk("mrst_ready", o_ll_ready, 1);
    chk("mrst_stall", o_stall, 0);
    rec_stale = 1'b1;
    repeat (10) tick();
    rec_stale = 1'b0;
    chk("mrst_no_stale", stale_cnt, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/rf_wr_arb.md
# rf_wr_arb

Arbiter for the single register-file write port. It sits after `wb` and merges two sources. The first is the in-order pipeline writeback from `wb`, which has priority. The second is results from long-latency units, which are buffered in a small FIFO. A starvation counter guarantees forward progress for the long-latency results by briefly stalling the pipeline.

## Interface
- `WORD_W`, 32, data width
- `REG_IDX_W`, 5, register index width
- `QDEPTH`, 2, long-latency FIFO depth (power of two, ≥2)
- `STARVE_MAX`, 4, consecutive denied cycles before a forced grant (≥1)

- `clk`  in  1  clock; all state on rising edge
- `clr`  in  1  reset, synchronous, active-high
- `i_pipe_en`  in  1  pipeline write request (from `wb` `o_dest_en`)
- `i_pipe_reg`  in  REG_IDX_W  pipeline destination register
- `i_pipe_data`  in  WORD_W  pipeline write data
- `i_ll_valid`  in  1  long-latency result valid
- `o_ll_ready`  out  1  FIFO can accept; transfer when valid&&ready
- `i_ll_reg`  in  REG_IDX_W  long-latency destination register
- `i_ll_data`  in  WORD_W  long-latency result
- `o_stall`  out  1  pipeline must freeze and re-present its write next cycle
- `o_busy`  out  1  FIFO non-empty
- `o_rf_we`  out  1  register-file write enable (registered)
- `o_rf_waddr`  out  REG_IDX_W  write address (registered)
- `o_rf_wdata`  out  WORD_W  write data (registered)

## Operation
- FIFO holds {reg, data}; `o_ll_ready = !full`. There is no pass-through when full, even if the head is granted in the same cycle.
- A write with reg index 0 is never issued, from either source.
  - Pipeline: treated as `i_pipe_en=0`.
  - Long-latency: accepted and dropped; it does not occupy a FIFO slot.
- Grant selection, evaluated each cycle in priority order:
  1. Forced: FIFO non-empty and `starve_cnt == STARVE_MAX`. Grant the FIFO head and assert `o_stall=1`. The pipeline write is not taken.
  2. Pipeline: `i_pipe_en=1`. Grant the pipeline write.
  3. FIFO: FIFO non-empty. Grant the head and pop.
  4. Bypass: FIFO empty and an `i_ll_valid` transfer is accepted. Write the long-latency result directly without enqueueing.
  5. None: `o_rf_we` deasserts next cycle.
- A long-latency transfer not consumed by bypass is pushed at the tail. Push and pop may occur in the same cycle; occupancy is then unchanged.
- `starve_cnt`:
  - Cleared when the FIFO is empty or the head is granted.
  - Otherwise incremented, saturating at `STARVE_MAX`.
- `o_stall` is combinational from state only: `(!empty && starve_cnt==STARVE_MAX)`. It never depends on the `i_*` inputs.
- Ordering: writes from each source leave in arrival order. Cross-source WAW ordering is the issuer's responsibility; `o_busy` is exported for that purpose.

## Timing
- Write latency is 1 cycle. The grant is decided in cycle N; `o_rf_we`, `o_rf_waddr` and `o_rf_wdata` are valid in cycle N+1.
- Minimum long-latency latency: 1 cycle via bypass; 2 or more cycles via the FIFO.
- `o_stall` lasts exactly 1 cycle per forced grant. During that cycle `wb` holds, so its request is presented again in the next cycle.
- Reset (`clr=1` at an edge):
  - FIFO emptied and queued entries discarded.
  - `starve_cnt=0`.
  - `o_rf_we=0`, `o_rf_waddr=0`, `o_rf_wdata=0`.
  - Inputs sampled in that cycle are ignored.
  - After that edge: `o_ll_ready=1`, `o_stall=0`, `o_busy=0`.
- Reset mid-operation: entries already in the FIFO are lost, and the long-latency producer must be reset together with this block.
- Full: `o_ll_ready=0` while occupancy equals `QDEPTH`. It rises one cycle after the pop that frees a slot.
- Steady state: with continuous `i_pipe_en`, each FIFO entry costs exactly 1 stall cycle, drawn once every `STARVE_MAX+1` cycles.

## Test plan
- **Bypass:** Idle state; `i_ll_valid=1`, reg=3, data=0xDEADBEEF for one cycle. The next cycle shows `o_rf_we=1`, waddr=3, wdata=0xDEADBEEF. `o_busy` stays 0 throughout.
- **Priority:** In the same cycle, present pipe (reg=5, data=0x11) and ll (reg=6, data=0x22).
  - N+1: reg5/0x11.
  - N+2: reg6/0x22 (from the FIFO).
  - `o_busy=1` only during N+1.
- **Starvation:** `STARVE_MAX=4`; `i_pipe_en` held high on reg 7; one long-latency entry is queued.
  - Exactly 4 cycles of pipe writes, then `o_stall=1` for 1 cycle.
  - The following write is the long-latency entry, and the held pipe write comes after it.
- **Full/backpressure:** With pipe busy, push 2 long-latency entries.
  - `o_ll_ready=0` while the third valid is held.
  - After the forced pop, ready returns and the third entry is accepted.
  - The 3 writes emerge in push order.
- **Reg-0 filter:** pipe reg=0 and ll reg=0 produce no `o_rf_we`. `o_busy` stays 0.
- **Reset mid-operation:** With the FIFO holding 2 entries, pulse `clr`. The next cycle shows `o_rf_we=0`, `o_busy=0`, `o_ll_ready=1`, and no stale writes ever appear.
